// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: packs streamed element pairs into lane vectors and launches the multiplier array
module matrix_operand_loader #(
  parameter int INPUT_PORTS = 4,
  parameter int BIT_LENGTH = 8
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIT_LENGTH-1:0]             in_multiplier,
  input  logic [BIT_LENGTH-1:0]             in_multiplicand,
  input  logic                              in_last,
  input  logic [INPUT_PORTS-1:0]            mult_ready,
  output logic [INPUT_PORTS*BIT_LENGTH*2-1:0] multiplier_out,
  output logic [INPUT_PORTS*BIT_LENGTH*2-1:0] multiplicand_out,
  output logic                              m_start,
  output logic                              busy,
  output logic [15:0]                       vec_count
);
  localparam int CW = INPUT_PORTS > 1 ? $clog2(INPUT_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [INPUT_PORTS-1:0][BIT_LENGTH-1:0] mr, md;
  logic xfer, done;
  assign xfer = in_valid & in_ready;
  assign done = xfer & (cnt == CW'(INPUT_PORTS-1) | in_last);
  assign multiplier_out = {{(INPUT_PORTS*BIT_LENGTH){1'b0}}, mr};
  assign multiplicand_out = {{(INPUT_PORTS*BIT_LENGTH){1'b0}}, md};
  always_ff @(posedge Clk)
    if (!Rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = done ? LAUNCH : xfer ? FILL : IDLE;
      FILL:    state_nx = done ? LAUNCH : FILL;
      LAUNCH:  state_nx = WAIT;
      default: state_nx = &mult_ready ? IDLE : WAIT;
    endcase
  end
  always_comb begin
    in_ready = Rst & (state == IDLE | state == FILL);
    m_start = state == LAUNCH;
    busy = state != IDLE;
  end
  // a lane-0 write clears the other lanes so short vectors read zero above their length
  always_ff @(posedge Clk)
    if (!Rst) begin
      cnt <= '0;
      mr <= '0;
      md <= '0;
      vec_count <= '0;
    end else begin
      if (xfer) begin
        if (cnt == '0) begin
          mr <= '0;
          md <= '0;
        end
        mr[cnt] <= in_multiplier;
        md[cnt] <= in_multiplicand;
        cnt <= done ? '0 : cnt + CW'(1);
      end
      if (state == LAUNCH) vec_count <= vec_count + 16'd1;
    end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: table-driven vectors with a launch scoreboard plus handwritten corner sequences
module tb_matrix_operand_loader;
  logic Clk = 0, Rst = 0, in_valid = 0, in_last = 0;
  logic [7:0] in_multiplier = 0, in_multiplicand = 0;
  logic [3:0] mult_ready = 4'hF;
  logic in_ready, m_start, busy;
  logic [63:0] multiplier_out, multiplicand_out;
  logic [15:0] vec_count;
  matrix_operand_loader #(.INPUT_PORTS(4), .BIT_LENGTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplier(in_multiplier), .in_multiplicand(in_multiplicand), .in_last(in_last),
    .mult_ready(mult_ready), .multiplier_out(multiplier_out), .multiplicand_out(multiplicand_out),
    .m_start(m_start), .busy(busy), .vec_count(vec_count)
  );
  always #5 Clk = ~Clk;
  typedef struct packed {
    logic [2:0] len;
    logic last;
    logic gap;
    logic [31:0] a, b, ea, eb;
  } vec_t;
  vec_t tbl [6];
  int checks = 0, errors = 0;
  logic [15:0] exp_cnt = 0;
  logic [63:0] q_a [$], q_b [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // every m_start must match the oldest completed vector
  always @(negedge Clk)
    if (m_start === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_m_start: got 1 expected 0");
      end else begin
        chk("mult_bus", multiplier_out, q_a.pop_front());
        chk("mcand_bus", multiplicand_out, q_b.pop_front());
      end
    end
  task automatic put(input logic [7:0] a, input logic [7:0] b, input logic l);
    int t = 0;
    in_valid = 1;
    in_multiplier = a;
    in_multiplicand = b;
    in_last = l;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready %b expected 1", in_ready);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy %b expected 0", busy);
    end
  endtask
  task automatic run_vec(input vec_t v);
    for (int k = 0; k < int'(v.len); k++) begin
      if (k == int'(v.len) - 1) begin
        q_a.push_back({32'h0, v.ea});
        q_b.push_back({32'h0, v.eb});
      end
      put(v.a[8*k +: 8], v.b[8*k +: 8], k == int'(v.len) - 1 && v.last);
      if (k == int'(v.len) - 1 || v.gap) in_valid = 0;
      if (v.gap && k != int'(v.len) - 1) @(negedge Clk);
    end
    in_last = 0;
    chk("latency_m_start", {63'h0, m_start}, 64'h1);
    exp_cnt++;
    wait_idle();
    chk("vec_count", {48'h0, vec_count}, {48'h0, exp_cnt});
    chk("ready_after", {63'h0, in_ready}, 64'h1);
  endtask
  initial begin
    tbl[0] = '{3'd4, 1'b0, 1'b0, 32'h07050301, 32'h08060402, 32'h07050301, 32'h08060402};
    tbl[1] = '{3'd2, 1'b1, 1'b0, 32'hCCCC0A09, 32'hCCCC0A09, 32'h00000A09, 32'h00000A09};
    tbl[2] = '{3'd4, 1'b0, 1'b1, 32'h44332211, 32'hD4C3B2A1, 32'h44332211, 32'hD4C3B2A1};
    tbl[3] = '{3'd1, 1'b1, 1'b0, 32'hCCCCCCFF, 32'hCCCCCC80, 32'h000000FF, 32'h00000080};
    tbl[4] = '{3'd4, 1'b1, 1'b0, 32'hEFBEADDE, 32'h04030201, 32'hEFBEADDE, 32'h04030201};
    tbl[5] = '{3'd3, 1'b1, 1'b1, 32'hCC090705, 32'hCC0A0806, 32'h00090705, 32'h000A0806};
    repeat (3) @(negedge Clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_m_start", {63'h0, m_start}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_mult", multiplier_out, 64'h0);
    chk("rst_mcand", multiplicand_out, 64'h0);
    chk("rst_vec_count", {48'h0, vec_count}, 64'h0);
    Rst = 1;
    @(negedge Clk);
    chk("ready_post_rst", {63'h0, in_ready}, 64'h1);
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    // backpressure: downstream holds one lane not ready while upstream keeps offering data
    mult_ready = 4'b0111;
    q_a.push_back({32'h0, 32'h07050301});
    q_b.push_back({32'h0, 32'h08060402});
    put(8'd1, 8'd2, 0);
    put(8'd3, 8'd4, 0);
    put(8'd5, 8'd6, 0);
    put(8'd7, 8'd8, 0);
    in_multiplier = 8'h55;
    in_multiplicand = 8'h66;
    in_last = 1;
    chk("bp_latency", {63'h0, m_start}, 64'h1);
    exp_cnt++;
    for (int c = 0; c < 6; c++) begin
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      chk("bp_busy", {63'h0, busy}, 64'h1);
      @(negedge Clk);
    end
    mult_ready = 4'hF;
    q_a.push_back({32'h0, 32'h00000055});
    q_b.push_back({32'h0, 32'h00000066});
    @(negedge Clk);
    chk("bp_release_ready", {63'h0, in_ready}, 64'h1);
    chk("bp_release_busy", {63'h0, busy}, 64'h0);
    chk("bp_no_extra", multiplier_out, 64'h07050301);
    chk("bp_vec_count", {48'h0, vec_count}, {48'h0, exp_cnt});
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 0;
    in_last = 0;
    chk("bp_held_launch", {63'h0, m_start}, 64'h1);
    exp_cnt++;
    wait_idle();
    chk("bp_vec_count2", {48'h0, vec_count}, {48'h0, exp_cnt});
    // reset mid-fill discards the partial vector
    put(8'h11, 8'h12, 0);
    put(8'h13, 8'h14, 0);
    in_valid = 0;
    Rst = 0;
    @(negedge Clk);
    chk("mf_mult", multiplier_out, 64'h0);
    chk("mf_mcand", multiplicand_out, 64'h0);
    chk("mf_busy", {63'h0, busy}, 64'h0);
    chk("mf_in_ready", {63'h0, in_ready}, 64'h0);
    chk("mf_vec_count", {48'h0, vec_count}, 64'h0);
    exp_cnt = 0;
    Rst = 1;
    @(negedge Clk);
    chk("mf_ready_after", {63'h0, in_ready}, 64'h1);
    run_vec(tbl[0]);
    // vec_count wrap from 0xFFFF
    force dut.vec_count = 16'hFFFF;
    #1;
    release dut.vec_count;
    @(negedge Clk);
    chk("wrap_preload", {48'h0, vec_count}, 64'hFFFF);
    exp_cnt = 16'hFFFF;
    run_vec(tbl[1]);
    chk("wrap_zero", {48'h0, vec_count}, 64'h0);
    repeat (3) @(negedge Clk);
    chk("queue_drained", 64'(q_a.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
